cyclic_bram_loader: RTL

Upstream stage of `always_valid_cyclic_bram`.
- Accepts one frame from an AXI-Stream-style source that can stall (valid/ready/last).
- Replays that frame as the always-valid write pattern the cyclic BRAM expects.
- Measures the frame length and drives the BRAM's `addr_max_1`.
- Holds the BRAM contents stable, with `loaded` high, until a `reload` request starts the next frame.

---
 rtl/cyclic_bram_loader_pkg.sv | 14 +
 rtl/cyclic_bram_loader_if.sv | 15 +
 rtl/cyclic_bram_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/cyclic_bram_loader_pkg.sv
// Shared types and defaults for the cyclic BRAM loader and its stream interface.
// Imported by the interface and the loader module.
package cyclic_bram_loader_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/cyclic_bram_loader_if.sv
// AXI-Stream-style beat channel (valid/ready/data/last) feeding the loader.
// The source drives the master side and the loader takes the slave side.
interface cyclic_bram_loader_if
    import cyclic_bram_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/cyclic_bram_loader.sv
// Captures one stream frame, replays it as always-valid BRAM writes and measures its
// length; the frame stays resident with loaded high until a reload starts the next one.
module cyclic_bram_loader
    import cyclic_bram_loader_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    cyclic_bram_loader_if.slave   s,
    input  logic                  reload,
    output logic                  m_valid_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_bram_rst,
    output logic [ADDR_WIDTH-1:0] addr_max_1,
    output logic                  loaded,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] count;
    logic                  ready;
    logic                  beat;

    // Ready must not wait on valid, otherwise a source that waits on ready deadlocks.
    assign ready   = clken && (state == LOAD || state == DRAIN);
    assign s.ready = ready;
    assign beat    = s.valid && ready;

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // a blocking = here would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LOAD;
            count         <= '0;
            m_valid_ready <= 1'b0;
            m_data        <= '0;
            m_bram_rst    <= 1'b1;
            addr_max_1    <= LAST_ADDR;
            loaded        <= 1'b0;
            overflow      <= 1'b0;
        end else if (clken) begin
            m_bram_rst    <= 1'b0;
            m_valid_ready <= 1'b0;
            case (state)
                LOAD: begin
                    if (beat) begin
                        m_valid_ready <= 1'b1;
                        m_data        <= s.data;
                        if (s.last) begin
                            // The last beat wins over overflow: exactly DEPTH beats is legal.
                            addr_max_1 <= count;
                            loaded     <= 1'b1;
                            state      <= HOLD;
                        end else if (count == LAST_ADDR) begin
                            addr_max_1 <= LAST_ADDR;
                            overflow   <= 1'b1;
                            state      <= DRAIN;
                        end else begin
                            // count only advances while staying in LOAD, so it never wraps.
                            count <= count + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && s.last) begin
                        loaded <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (reload) begin
                        m_bram_rst <= 1'b1;
                        count      <= '0;
                        loaded     <= 1'b0;
                        overflow   <= 1'b0;
                        state      <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
